// File: rtl/seq_alu_pkg.sv
// rtl/seq_alu_pkg.sv - shared opcodes, FSM states and flag indices for seq_alu
package seq_alu_pkg;

    localparam logic [3:0] OP_PASS = 4'b0000;
    localparam logic [3:0] OP_NOT  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b1001;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;
    localparam logic [3:0] OP_MUL  = 4'b1100;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    // Bit positions inside the 3-bit flags word {zero, carry, ovf}
    localparam int ZF = 2;
    localparam int CF = 1;
    localparam int VF = 0;

endpackage

// File: rtl/seq_alu_mul.sv
// rtl/seq_alu_mul.sv - iterative shift-add multiplier, one partial product per cycle
module seq_alu_mul
    import seq_alu_pkg::*;
#(
    parameter int N   = 32,
    parameter int SHW = $clog2(N)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic         o_done,
    output logic [N-1:0] o_product
);

    logic [N-1:0]   r_acc;
    logic [N-1:0]   r_mcand;
    logic [N-1:0]   r_mplier;
    logic [SHW-1:0] r_cnt;
    logic           r_busy;

    logic [N-1:0]   w_acc_next;
    logic           w_last;

    // Partial-product add for the current multiplier bit; bits above N fall off
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_last     = (r_cnt == SHW'(N - 1));
    assign o_done     = r_busy && w_last;
    // The final product is the accumulator value being written on the done edge
    assign o_product  = w_acc_next;

    // Load operands on start, then shift multiplicand left / multiplier right each cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (w_last) begin
                r_cnt  <= '0;
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt + SHW'(1);
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - sequential ALU with single-cycle ops and an iterative multiply
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int N   = 32,
    parameter int SHW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic [2:0]   flags,
    output logic         err
);

    state_e         r_state;
    state_e         w_state_next;

    logic [N-1:0]   r_result;
    logic [2:0]     r_flags;
    logic           r_err;
    logic           r_out_valid;

    logic           w_accept;
    logic           w_mul_start;
    logic           w_mul_done;
    logic [N-1:0]   w_mul_product;

    logic [N-1:0]   w_res;
    logic [2:0]     w_flags;
    logic           w_err;
    logic [N:0]     w_sum;
    logic [N:0]     w_diff;
    logic [SHW-1:0] w_shamt;

    // in_ready is forced low during reset so nothing is accepted while rst is held
    assign in_ready    = !rst && (r_state == ST_IDLE) && (!r_out_valid || out_ready);
    assign w_accept    = in_valid && in_ready;
    assign w_mul_start = w_accept && (op == OP_MUL);

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flags     = r_flags;
    assign err       = r_err;

    seq_alu_mul #(
        .N   (N),
        .SHW (SHW)
    ) u_mul (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (w_mul_start),
        .i_a       (a),
        .i_b       (b),
        .o_done    (w_mul_done),
        .o_product (w_mul_product)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: IDLE waits for a MUL request, MUL waits for the multiplier to finish
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_mul_start) w_state_next = ST_MUL;
            ST_MUL:  if (w_mul_done)  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Single-cycle datapath: result, flags and err for every non-MUL opcode
    always_comb begin
        w_res   = '0;
        w_flags = '0;
        w_err   = 1'b0;
        w_sum   = {1'b0, a} + {1'b0, b};
        w_diff  = {1'b0, a} - {1'b0, b};
        w_shamt = b[SHW-1:0];
        case (op)
            OP_PASS: w_res = a;
            OP_NOT:  w_res = ~a;
            OP_ADD: begin
                w_res       = w_sum[N-1:0];
                w_flags[CF] = w_sum[N];
                w_flags[VF] = (a[N-1] == b[N-1]) && (w_sum[N-1] != a[N-1]);
            end
            OP_SUB: begin
                w_res       = w_diff[N-1:0];
                // The borrow out of the widened subtraction is exactly unsigned a < b
                w_flags[CF] = w_diff[N];
                w_flags[VF] = (a[N-1] != b[N-1]) && (w_diff[N-1] != a[N-1]);
            end
            OP_OR:   w_res = a | b;
            OP_AND:  w_res = a & b;
            OP_SLT:  w_res = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: w_res = {{(N-1){1'b0}}, (a < b)};
            OP_XOR:  w_res = a ^ b;
            OP_SLL:  w_res = a << w_shamt;
            OP_SRL:  w_res = a >> w_shamt;
            OP_SRA:  w_res = $signed(a) >>> w_shamt;
            OP_MUL:  w_res = '0;
            default: w_err = 1'b1;
        endcase
        if (!w_err) begin
            w_flags[ZF] = (w_res == '0);
        end
    end

    // Output register: single-cycle results win, then multiplier completion, then drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result    <= '0;
            r_flags     <= '0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_accept && (op != OP_MUL)) begin
            r_result    <= w_res;
            r_flags     <= w_flags;
            r_err       <= w_err;
            r_out_valid <= 1'b1;
        end else if (w_mul_done) begin
            r_result    <= w_mul_product;
            r_flags     <= {(w_mul_product == '0), 1'b0, 1'b0};
            r_err       <= 1'b0;
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - directed self-checking bench for seq_alu
module tb_seq_alu;

    localparam int N = 32;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic [2:0]   flags;
    logic         err;

    int n_assert = 0;
    int n_fail   = 0;

    seq_alu #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] o, input logic [N-1:0] aa, input logic [N-1:0] bb);
        in_valid = v;
        op       = o;
        a        = aa;
        b        = bb;
    endtask

    initial begin
        int bad;
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 4'h0, '0, '0);

        // Reset state
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", flags, 0);
        chk("rst_err", err, 0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // Back-to-back ADD then SUB
        drive(1'b1, 4'h2, 32'd7, 32'd5);
        step();
        chk("add_valid", out_valid, 1);
        chk("add_result", result, 32'd12);
        chk("add_flags", flags, 3'b000);
        chk("add_in_ready", in_ready, 1);
        drive(1'b1, 4'h3, 32'd3, 32'd5);
        step();
        chk("sub_valid", out_valid, 1);
        chk("sub_result", result, 32'hFFFF_FFFE);
        chk("sub_flags", flags, 3'b010);

        // Overflow and carry
        drive(1'b1, 4'h2, 32'h7FFF_FFFF, 32'd1);
        step();
        chk("ovf_result", result, 32'h8000_0000);
        chk("ovf_flags", flags, 3'b001);
        drive(1'b1, 4'h2, 32'hFFFF_FFFF, 32'd1);
        step();
        chk("carry_result", result, 32'd0);
        chk("carry_flags", flags, 3'b110);
        drive(1'b0, 4'h0, '0, '0);
        step();
        chk("drain_valid", out_valid, 0);

        // MUL 1234 * -3; an ADD held on the inputs during MUL must be ignored
        drive(1'b1, 4'hC, 32'd1234, 32'hFFFF_FFFD);
        step();
        chk("mul_busy_in_ready", in_ready, 0);
        drive(1'b1, 4'h2, 32'd1, 32'd1);
        bad = 0;
        for (int i = 1; i < N; i++) begin
            step();
            if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
        end
        chk("mul_busy_cycles", bad, 0);
        step();
        chk("mul_valid", out_valid, 1);
        chk("mul_result", result, 32'hFFFF_F18A);
        chk("mul_flags", flags, 3'b000);
        drive(1'b0, 4'h0, '0, '0);
        step();
        chk("mul_drain", out_valid, 0);

        // Backpressure after OR
        out_ready = 1'b0;
        drive(1'b1, 4'h4, 32'h0000_00F0, 32'h0000_000F);
        step();
        chk("or_result", result, 32'h0000_00FF);
        chk("or_valid", out_valid, 1);
        drive(1'b1, 4'h5, 32'h0000_00FF, 32'h0000_000F);
        chk("bp_in_ready0", in_ready, 0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (result !== 32'h0000_00FF || out_valid !== 1'b1 || in_ready !== 1'b0 || flags !== 3'b000) bad++;
        end
        chk("bp_hold_cycles", bad, 0);
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", in_ready, 1);
        step();
        chk("and_result", result, 32'h0000_000F);
        chk("and_valid", out_valid, 1);
        drive(1'b0, 4'h0, '0, '0);
        step();

        // Reset 10 cycles into a MUL
        drive(1'b1, 4'hC, 32'd5, 32'd7);
        step();
        drive(1'b0, 4'h0, '0, '0);
        for (int i = 0; i < 9; i++) step();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("midrst_release_ready", in_ready, 1);
        bad = 0;
        for (int i = 0; i < N + 8; i++) begin
            step();
            if (out_valid !== 1'b0) bad++;
        end
        chk("midrst_no_result", bad, 0);
        drive(1'b1, 4'h6, 32'hFFFF_FFFE, 32'd1);
        step();
        chk("slt_result", result, 32'd1);
        chk("slt_flags", flags, 3'b000);
        drive(1'b1, 4'h7, 32'hFFFF_FFFE, 32'd1);
        step();
        chk("sltu_result", result, 32'd0);
        chk("sltu_flags", flags, 3'b100);

        // Shifts, amount masking and illegal ops
        drive(1'b1, 4'hB, 32'h8000_0000, 32'h0000_0021);
        step();
        chk("sra_result", result, 32'hC000_0000);
        drive(1'b1, 4'h9, 32'h0000_1234, 32'h0000_0020);
        step();
        chk("sll_zero_amt", result, 32'h0000_1234);
        drive(1'b1, 4'hA, 32'h8000_0000, 32'd4);
        step();
        chk("srl_result", result, 32'h0800_0000);
        drive(1'b1, 4'hF, 32'd5, 32'd5);
        step();
        chk("ill_valid", out_valid, 1);
        chk("ill_err", err, 1);
        chk("ill_result", result, 0);
        chk("ill_flags", flags, 3'b000);
        drive(1'b1, 4'h8, 32'hFF00_FF00, 32'h0F0F_0F0F);
        step();
        chk("xor_result", result, 32'hF00F_F00F);
        chk("xor_err", err, 0);
        drive(1'b1, 4'h1, 32'hFFFF_FFFF, 32'd0);
        step();
        chk("not_result", result, 32'd0);
        chk("not_flags", flags, 3'b100);
        drive(1'b0, 4'h0, '0, '0);
        step();
        chk("final_drain", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter N, default 32: operand/result width in bits, N >= 4 and a power of two.
REQ-002 SHALL have parameter SHW, default $clog2(N): shift-amount width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: a request is present on a, b and op.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept a request this cycle.
REQ-007 SHALL have port a, input, N bits: operand A, signed two's complement.
REQ-008 SHALL have port b, input, N bits: operand B, signed two's complement.
REQ-009 SHALL have port op, input, 4 bits: opcode.
REQ-010 SHALL have port out_valid, output, 1 bit: result, flags and err hold a valid result.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-012 SHALL have port result, output, N bits: the registered result.
REQ-013 SHALL have port flags, output, 3 bits: {zero, carry, ovf}, registered with result.
REQ-014 SHALL have port err, output, 1 bit: illegal opcode, registered with result.

Function
REQ-015 SHALL implement these opcodes: 0000 A; 0001 ~A; 0010 A+B; 0011 A-B; 0100 A|B; 0101 A&B; 0110 signed A<B (zero-extended 0/1); 0111 unsigned A<B; 1000 A^B; 1001 A<<B[SHW-1:0]; 1010 logical A>>B[SHW-1:0]; 1011 arithmetic A>>>B[SHW-1:0]; 1100 MUL, low N bits of A*B.
REQ-016 SHALL treat opcodes 1101-1111 as illegal: result 0, err=1, flags 0, latency 1.
REQ-017 SHALL accept a request on a rising edge where in_valid and in_ready are both 1, and SHALL capture a, b and op on that edge.
REQ-018 SHALL drive in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-019 SHALL make every non-MUL op latency 1: request accepted on edge k gives out_valid=1 with the result after edge k.
REQ-020 SHALL run MUL as an iterative shift-add over N cycles: accept on edge k; FSM state MUL for edges k+1..k+N; result and out_valid=1 after edge k+N.
REQ-021 SHALL use FSM states IDLE and MUL only.
- IDLE -> MUL on acceptance of op 1100.
- MUL -> IDLE when the iteration counter reaches N-1 (counter counts 0..N-1).
REQ-022 SHALL hold result, flags, err and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL clear out_valid on an edge with out_ready=1 unless a new latency-1 result is written on that same edge (back-to-back throughput of 1 per cycle).
REQ-024 SHALL ignore in_valid while in MUL, and in_ready SHALL be 0 there.
REQ-025 SHALL set zero = (result == 0) for all legal ops.
REQ-026 SHALL set carry only for ADD (carry-out) and SUB (borrow, i.e. unsigned A<B); otherwise carry=0.
REQ-027 SHALL set ovf only for ADD and SUB (signed overflow); otherwise ovf=0.
REQ-028 SHALL discard multiply overflow beyond N bits without flagging it.
REQ-029 SHALL treat a shift amount of 0 as a pass-through of A.
REQ-030 SHALL use only B[SHW-1:0] as the shift amount, ignoring upper bits of B.

Reset
REQ-031 SHALL, on rst=1 regardless of clock, set state=IDLE, counter=0, out_valid=0, result=0, flags=0 and err=0.
REQ-032 SHALL abort an in-progress MUL on reset mid-operation, with no result ever presented.
REQ-033 SHALL hold in_ready=0 while rst=1 and SHALL assert it in the first cycle after rst deasserts.

Structure
REQ-034 SHALL define in the shared package seq_alu_pkg:
- opcode localparams/enum (OP_PASS..OP_MUL);
- FSM state enum;
- flag bit indices ZF=2, CF=1, VF=0.
REQ-035 SHALL place the iterative multiplier in sub-module seq_alu_mul, which has start/done handshake and accumulator, multiplicand and multiplier registers.
REQ-036 SHALL compute the combinational ops in a single always block feeding the output register.

Verification
REQ-037 SHALL cover basic ops: N=32, back-to-back ADD 7+5 then SUB 3-5, out_ready=1 -> results 12 then 0xFFFFFFFE on consecutive cycles; SUB flags carry=1, ovf=0.
REQ-038 SHALL cover overflow: ADD 0x7FFFFFFF+1 -> result 0x80000000, ovf=1, carry=0; ADD 0xFFFFFFFF+1 -> result 0, zero=1, carry=1.
REQ-039 SHALL cover MUL: 1234*(-3) -> result 0xFFFFF18A exactly N=32 cycles after acceptance; in_ready=0 throughout the MUL.
REQ-040 SHALL cover backpressure: out_ready=0 for 5 cycles after an OR result -> result stable and in_ready=0 throughout; releasing out_ready in the same cycle as a new in_valid -> new result after the next edge.
REQ-041 SHALL cover reset mid-MUL: rst asserted 10 cycles into a MUL -> out_valid stays 0; a following SLT -2<1 -> result 1, while SLTU on the same operands -> 0.
REQ-042 SHALL cover shifts and illegal ops: SRA 0x80000000 by B=0x21 (amount 1) -> 0xC0000000; op 1111 -> err=1, result 0.
